// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared types and constants for the gate truth-table sequencer
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        REPORT = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    localparam int NUM_COMBOS = 4;
    localparam int GATE_S_W   = 8;
    localparam int SEL_BASE   = 2;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    // One-hot select above the operand bits, operands {s1,s0} = k.
    function automatic logic [GATE_S_W-1:0] drive_pattern(input logic [2:0] idx,
                                                          input logic [1:0] k);
        logic [GATE_S_W-1:0] p;
        p      = GATE_S_W'(1) << (SEL_BASE + int'(idx));
        p[1:0] = k;
        return p;
    endfunction

endpackage

// File: rtl/gate_test_sequencer_if.sv
// rtl/gate_test_sequencer_if.sv - gate drive and truth-table result bundle
interface gate_test_sequencer_if;
    import gate_seq_pkg::*;

    logic [GATE_S_W-1:0] gate_s;
    logic                gate_y;
    logic                busy;
    logic                result_valid;
    logic [2:0]          result_idx;
    logic [3:0]          result_tt;
    logic                done;

    modport master (
        output gate_s,
        input  gate_y,
        output busy,
        output result_valid,
        output result_idx,
        output result_tt,
        output done
    );

    modport slave (
        input  gate_s,
        output gate_y,
        input  busy,
        input  result_valid,
        input  result_idx,
        input  result_tt,
        input  done
    );

endinterface

// File: rtl/start_sync_edge.sv
// rtl/start_sync_edge.sv - start synchronizer and rise detect; GATE_SEQ_DEBOUNCE_EN adds a stability filter
module start_sync_edge #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;
    logic level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= start;
            sync2 <= sync1;
        end
    end

`ifdef GATE_SEQ_DEBOUNCE_EN
    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DCNT_W-1:0] dcnt;
    logic              filt;

    // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= '0;
            filt <= 1'b0;
        end else if (sync2 == filt) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
            dcnt <= '0;
            filt <= sync2;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    assign level = filt;
    assign rise  = level & ~prev;
`else
    localparam logic CFG_OK = (DEBOUNCE_CYCLES >= 1);

    assign level = sync2;
    assign rise  = level & ~prev & CFG_OK;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

endmodule

// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - truth-table sweep sequencer for the 8-input gate; GATE_SEQ_DEBOUNCE_EN filters start
module gate_test_sequencer
    import gate_seq_pkg::*;
#(
    parameter int NUM_SEL         = 6,
    parameter int DWELL           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GATE_S_W-1:0]   sw,
    input  logic                  start,
    gate_test_sequencer_if.master bus
);

    localparam int              CNT_W    = $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [2:0]      IDX_LAST = 3'(NUM_SEL - 1);
    localparam logic [1:0]      K_LAST   = 2'(NUM_COMBOS - 1);

    seq_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          k;
    logic [2:0]          idx;
    logic [2:0]          tt;
    logic                rise;

    logic [GATE_S_W-1:0] gate_s_q;
    logic                busy_q;
    logic                result_valid_q;
    logic [2:0]          result_idx_q;
    logic [3:0]          result_tt_q;
    logic                done_q;

    start_sync_edge #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            k              <= '0;
            idx            <= '0;
            tt             <= '0;
            gate_s_q       <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_idx_q   <= '0;
            result_tt_q    <= '0;
            done_q         <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            case (state)
                IDLE: begin
                    gate_s_q <= sw;
                    if (rise) begin
                        state    <= DRIVE;
                        busy_q   <= 1'b1;
                        idx      <= '0;
                        k        <= '0;
                        cnt      <= '0;
                        gate_s_q <= drive_pattern(3'd0, 2'd0);
                    end
                end
                DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (k == K_LAST) begin
                            // Last combination's sample goes straight into the report.
                            state          <= REPORT;
                            result_valid_q <= 1'b1;
                            result_idx_q   <= idx;
                            result_tt_q    <= {bus.gate_y, tt};
                        end else begin
                            tt[k]    <= bus.gate_y;
                            k        <= k + 2'd1;
                            gate_s_q <= drive_pattern(idx, k + 2'd1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REPORT: begin
                    if (idx == IDX_LAST) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state    <= DRIVE;
                        idx      <= idx + 3'd1;
                        k        <= '0;
                        cnt      <= '0;
                        gate_s_q <= drive_pattern(idx + 3'd1, 2'd0);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    gate_s_q <= sw;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gate_s       = gate_s_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_idx   = result_idx_q;
    assign bus.result_tt    = result_tt_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - directed self-checking bench for gate_test_sequencer
module tb_gate_test_sequencer;
    import gate_seq_pkg::*;

`ifdef GATE_SEQ_DEBOUNCE_EN
    localparam int ENTRY = 19;
`else
    localparam int ENTRY = 3;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] sw    = 8'h00;
    logic       y;

    int checks   = 0;
    int failures = 0;

    gate_test_sequencer_if bus ();

    gate_test_sequencer #(
        .NUM_SEL         (6),
        .DWELL           (4),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .start (start),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        y = 1'b0;
        case (bus.gate_s[7:2])
            6'b000001: y = bus.gate_s[0] & bus.gate_s[1];
            6'b000010: y = bus.gate_s[0] | bus.gate_s[1];
            6'b000100: y = bus.gate_s[0] ^ bus.gate_s[1];
            6'b001000: y = ~(bus.gate_s[0] & bus.gate_s[1]);
            6'b010000: y = 1'b0;
            6'b100000: y = 1'b1;
            default:   y = 1'b0;
        endcase
    end
    assign bus.gate_y = y;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pat(input int c);
        int sel;
        int kk;
        logic [7:0] p;
        sel = c / 17;
        kk  = (c % 17) / 4;
        p   = 8'd1 << (2 + sel);
        p   = p | 8'(kk);
        return p;
    endfunction

    initial begin
        logic [3:0] exp_tt [6];
        int         vcyc [6];
        logic [2:0] vidx [6];
        logic [3:0] vtt [6];
        int n;
        int nv;
        int ndone;
        int done_cyc;
        int busy_cnt;
        int saw;

        exp_tt[0] = TT_AND;  exp_tt[1] = TT_OR;   exp_tt[2] = TT_XOR;
        exp_tt[3] = TT_NAND; exp_tt[4] = 4'h0;    exp_tt[5] = 4'hF;

        repeat (3) @(posedge clk);
        #1;
        check("rst_gate_s", 32'(bus.gate_s), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_result_valid", 32'(bus.result_valid), 32'h0);
        check("rst_result_idx", 32'(bus.result_idx), 32'h0);
        check("rst_result_tt", 32'(bus.result_tt), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);

        @(negedge clk); rst_n = 1'b1; sw = 8'hA5;
        @(posedge clk); #1;
        check("pass_a5", 32'(bus.gate_s), 32'hA5);
        check("pass_busy", 32'(bus.busy), 32'h0);
        @(negedge clk); sw = 8'h3C;
        @(posedge clk); #1;
        check("pass_3c", 32'(bus.gate_s), 32'h3C);

        // Sweep with start held high and mid-sweep disturbances
        @(negedge clk); start = 1'b1;
        n = 0;
        while (!bus.busy && n < 60) begin
            @(posedge clk); #1; n++;
        end
        check("entry_edges", 32'(n), 32'(ENTRY));
        check("first_drive", 32'(bus.gate_s), 32'h04);

        nv = 0; ndone = 0; done_cyc = -1; busy_cnt = 0;
        for (int c = 0; c < 120; c++) begin
            if (bus.busy) busy_cnt++;
            if (bus.result_valid) begin
                if (nv < 6) begin
                    vcyc[nv] = c; vidx[nv] = bus.result_idx; vtt[nv] = bus.result_tt;
                end
                nv++;
            end
            if (bus.done) begin
                ndone++; done_cyc = c;
            end
            if (c < 102 && (c % 17) < 16) check("gate_s_drive", 32'(bus.gate_s), 32'(exp_pat(c)));
            if (c == 38) check("drive_idx2_k1", 32'(bus.gate_s), 32'h11);
            if (c == 103) check("busy_after_done", 32'(bus.busy), 32'h0);
            if (c == 104) check("pass_after_sweep", 32'(bus.gate_s), 32'hFF);
            @(negedge clk);
            if (c == 20) sw = 8'hFF;
            if (c == 50) start = 1'b0;
            if (c == 53) start = 1'b1;
            @(posedge clk); #1;
        end
        check("valid_count", 32'(nv), 32'd6);
        for (int i = 0; i < 6 && i < nv; i++) begin
            check("result_idx", 32'(vidx[i]), 32'(i));
            check("result_tt", 32'(vtt[i]), 32'(exp_tt[i]));
            check("valid_cycle", 32'(vcyc[i]), 32'(16 + 17 * i));
        end
        check("done_count", 32'(ndone), 32'd1);
        check("done_cycle", 32'(done_cyc), 32'd102);
        check("busy_cycles", 32'(busy_cnt), 32'd103);
        check("held_idx", 32'(bus.result_idx), 32'd5);
        check("held_tt", 32'(bus.result_tt), 32'hF);

        // Reset mid-sweep during idx 3
        @(negedge clk); start = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk); start = 1'b1;
        n = 0;
        while (!bus.busy && n < 60) begin
            @(posedge clk); #1; n++;
        end
        check("entry2_edges", 32'(n), 32'(ENTRY));
        repeat (56) @(posedge clk);
        #1;
        check("pre_reset_drive", 32'(bus.gate_s), 32'h21);
        check("pre_reset_idx", 32'(bus.result_idx), 32'd2);
        @(negedge clk); rst_n = 1'b0; start = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_gate_s", 32'(bus.gate_s), 32'h0);
        check("abort_result_valid", 32'(bus.result_valid), 32'h0);
        check("abort_result_idx", 32'(bus.result_idx), 32'h0);
        check("abort_result_tt", 32'(bus.result_tt), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        saw = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy || bus.result_valid) saw++;
        end
        check("no_activity_after_abort", 32'(saw), 32'h0);
        @(negedge clk); start = 1'b1;
        n = 0;
        while (!bus.result_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("restart_found_result", 32'(n < 200), 32'h1);
        check("restart_idx", 32'(bus.result_idx), 32'h0);
        check("restart_tt", 32'(bus.result_tt), 32'(TT_AND));
        n = 0;
        while (!bus.done && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("restart_done", 32'(bus.done), 32'h1);
        @(negedge clk); start = 1'b0;
        repeat (30) @(posedge clk);

`ifdef GATE_SEQ_DEBOUNCE_EN
        // Short pulse rejected, long pulse accepted after the filter delay
        @(negedge clk); start = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        saw = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.busy) saw++;
        end
        check("deb_short_reject", 32'(saw), 32'h0);
        @(negedge clk); start = 1'b1;
        n = 0;
        while (!bus.busy && n < 60) begin
            @(posedge clk); #1; n++;
        end
        check("deb_long_entry", 32'(n), 32'd19);
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!bus.done && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("deb_done", 32'(bus.done), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
